imm_extend_pipe: RTL and testbench

- Registered, handshaked immediate generator; next generation of the single-cycle Extend block, for the pipelined core's decode stage.
- Generalises immediate extension to XLEN 32/64 and adds shift-amount and CSR-uimm formats, illegal-format flagging, a tag passthrough and an error counter.
- Sits between the fetch/decode register and the ID/EX register.
- Uses a 2-entry skid buffer so it sustains one immediate per cycle with a registered in_ready.

---
 rtl/rv_imm_pkg.sv | 18 +
 rtl/imm_decode.sv | 30 +++
 rtl/imm_extend_pipe.sv | 89 ++++++++
 tb/tb_imm_extend_pipe.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rv_imm_pkg.sv
// rv_imm_pkg: immediate format codes and buffered entry layout for the decode-stage immediate generator
package rv_imm_pkg;
  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_CSR   = 3'b110;
  localparam logic [2:0] IMM_ILL   = 3'b111;
  localparam int IMM_XLEN  = 32;
  localparam int IMM_TAG_W = 5;
  typedef struct packed {
    logic [IMM_XLEN-1:0]  imm;
    logic [IMM_TAG_W-1:0] tag;
    logic                 illegal;
  } imm_entry_t;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate extraction; instr[31:7] + imm_src -> XLEN immediate + illegal flag
module imm_decode
  import rv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  logic [31:0] raw;
  // raw is always a correctly sign-extended 32-bit value; zero-extended formats have raw[31]=0,
  // so a single signed widening covers every format for XLEN=64
  always_comb begin
    raw = '0;
    case (imm_src)
      IMM_I:     raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:     raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:     raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:     raw = {instr[31:12], 12'b0};
      IMM_SHAMT: raw = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
      IMM_CSR:   raw = {27'b0, instr[19:15]};
      default:   raw = '0;
    endcase
  end
  assign imm     = XLEN'($signed(raw));
  assign illegal = imm_src == IMM_ILL;
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered, handshaked immediate generator with a 2-entry skid buffer.
// Ports: clk/reset (async, active-low), flush; request side in_valid/in_ready/instr/imm_src/in_tag;
// result side out_valid/out_ready/imm_ext/out_tag/out_illegal; err_cnt counts accepted illegal requests.
module imm_extend_pipe
  import rv_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [CNT_W-1:0] err_cnt
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;
  entry_t           m_q, m_d, s_q, s_d, new_e;
  logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d, in_ready_q, in_ready_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_ill, accept;
  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr  (instr),
    .imm_src(imm_src),
    .imm    (dec_imm),
    .illegal(dec_ill)
  );
  assign new_e  = '{imm: dec_imm, tag: in_tag, illegal: dec_ill};
  assign accept = in_valid && in_ready_q;
  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q) begin
      m_d       = accept ? new_e : m_q;
      m_valid_d = accept;
    end else if (out_ready) begin
      m_d       = s_valid_q ? s_q : accept ? new_e : m_q;
      m_valid_d = s_valid_q || accept;
      s_valid_d = 1'b0;
    end else if (accept) begin
      s_d       = new_e;
      s_valid_d = 1'b1;
    end
    // registered ready: it only depends on whether the skid slot will be occupied
    in_ready_d = !s_valid_d;
    err_cnt_d  = (accept && dec_ill && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      m_q        <= '0;
      s_q        <= '0;
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
      err_cnt_q  <= '0;
    end else begin
      m_q        <= m_d;
      s_q        <= s_d;
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
      err_cnt_q  <= err_cnt_d;
    end
  assign in_ready    = in_ready_q;
  assign out_valid   = m_valid_q;
  assign imm_ext     = m_q.imm;
  assign out_tag     = m_q.tag;
  assign out_illegal = m_q.illegal;
  assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: XLEN=32 and XLEN=64 instances on shared stimulus, checked against a queue-based model
module tb_imm_extend_pipe;
  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] instr_w;
  logic [2:0]  imm_src;
  logic [4:0]  in_tag;
  logic        ir32, ov32, il32, ir64, ov64, il64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tag32, tag64;
  logic [7:0]  err32, err64;
  int checks = 0, errors = 0, err_m = 0;
  typedef struct {
    logic [31:0] ins;
    logic [2:0]  src;
    logic [4:0]  tag;
  } req_t;
  req_t q[$];
  imm_extend_pipe #(.XLEN(32)) d32 (
    .clk(clk), .reset(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .instr(instr_w[31:7]), .imm_src(imm_src), .in_tag(in_tag), .out_valid(ov32),
    .out_ready(out_ready), .imm_ext(imm32), .out_tag(tag32), .out_illegal(il32), .err_cnt(err32)
  );
  imm_extend_pipe #(.XLEN(64)) d64 (
    .clk(clk), .reset(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .instr(instr_w[31:7]), .imm_src(imm_src), .in_tag(in_tag), .out_valid(ov64),
    .out_ready(out_ready), .imm_ext(imm64), .out_tag(tag64), .out_illegal(il64), .err_cnt(err64)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // immediate value built arithmetically from the instruction fields
  function automatic logic [63:0] ref_imm(input int xlen, input logic [31:0] i, input logic [2:0] src);
    longint s  = longint'($signed(i));
    longint sg = i[31] ? -1 : 0;
    longint r;
    case (src)
      3'd0:    r = s >>> 20;
      3'd1:    r = (s >>> 25) * 32 + longint'(i[11:7]);
      3'd2:    r = sg * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      3'd3:    r = sg * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      3'd4:    r = (s >>> 12) * 4096;
      3'd5:    r = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
      3'd6:    r = longint'(i[19:15]);
      default: r = 0;
    endcase
    return (xlen == 32) ? {32'b0, r[31:0]} : r;
  endfunction
  task automatic check_outputs();
    chk("out_valid32", ov32, q.size() > 0);
    chk("out_valid64", ov64, q.size() > 0);
    chk("in_ready32", ir32, q.size() < 2);
    chk("in_ready64", ir64, q.size() < 2);
    chk("err_cnt32", err32, err_m);
    chk("err_cnt64", err64, err_m);
    if (q.size() > 0) begin
      chk("imm32", imm32, ref_imm(32, q[0].ins, q[0].src));
      chk("imm64", imm64, ref_imm(64, q[0].ins, q[0].src));
      chk("tag32", tag32, q[0].tag);
      chk("tag64", tag64, q[0].tag);
      chk("illegal32", il32, q[0].src == 3'd7);
      chk("illegal64", il64, q[0].src == 3'd7);
    end
  endtask
  // called at a negedge: check current outputs, apply inputs, advance the model, wait one cycle
  task automatic tick(input logic v, input logic [31:0] ins, input logic [2:0] src,
                      input logic [4:0] tg, input logic fl, input logic ordy);
    logic acc, fire;
    check_outputs();
    in_valid = v; instr_w = ins; imm_src = src; in_tag = tg; flush = fl; out_ready = ordy;
    acc  = v && (q.size() < 2);
    fire = (q.size() > 0) && ordy;
    if (acc && src == 3'd7 && err_m < 255) err_m++;
    if (fl) q.delete();
    else begin
      if (fire) void'(q.pop_front());
      if (acc) q.push_back('{ins, src, tg});
    end
    @(negedge clk);
  endtask
  logic [31:0] vin[9]  = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h001000EF, 32'h123452B7,
                           32'hFFF00093, 32'h800002B7, 32'h03F0D093, 32'h3400A073};
  logic [2:0]  vsrc[9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd4, 3'd5, 3'd6};
  logic [31:0] v32[9]  = '{32'hFFFFFFFF, 32'h8, 32'hFFFFFFFC, 32'h800, 32'h12345000,
                           32'hFFFFFFFF, 32'h80000000, 32'h1F, 32'h1};
  logic [63:0] v64[9]  = '{64'hFFFFFFFFFFFFFFFF, 64'h8, 64'hFFFFFFFFFFFFFFFC, 64'h800, 64'h12345000,
                           64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'h3F, 64'h1};
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr_w = '0; imm_src = '0; in_tag = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_imm32", imm32, 0);
    chk("rst_tag64", tag64, 0);
    chk("rst_ill32", il32, 0);
    check_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    // back-to-back known vectors, one result per cycle
    for (int k = 0; k < 9; k++) begin
      tick(1'b1, vin[k], vsrc[k], 5'(k), 1'b0, 1'b1);
      chk("vec_imm32", imm32, v32[k]);
      chk("vec_imm64", imm64, v64[k]);
      chk("vec_ready", ir32, 1);
    end
    tick(1'b0, 0, 0, 0, 1'b0, 1'b1);
    // backpressure: tags 1 and 2 fill M and S, tag 3 stalls
    tick(1'b1, 32'hFFF00093, 3'd0, 5'd1, 1'b0, 1'b0);
    tick(1'b1, 32'h0020A423, 3'd1, 5'd2, 1'b0, 1'b0);
    chk("bp_in_ready", ir32, 0);
    tick(1'b1, 32'h123452B7, 3'd4, 5'd3, 1'b0, 1'b0);
    tick(1'b1, 32'h123452B7, 3'd4, 5'd3, 1'b0, 1'b0);
    chk("bp_hold_tag", tag32, 1);
    chk("bp_hold_imm", imm32, 32'hFFFFFFFF);
    tick(1'b1, 32'h123452B7, 3'd4, 5'd3, 1'b0, 1'b1);
    chk("bp_tag2", tag32, 2);
    tick(1'b1, 32'h123452B7, 3'd4, 5'd3, 1'b0, 1'b1);
    chk("bp_tag3", tag64, 3);
    tick(1'b0, 0, 0, 0, 1'b0, 1'b1);
    // flush with both entries full, then flush alongside an accept
    tick(1'b1, 32'hFFF00093, 3'd7, 5'd4, 1'b0, 1'b0);
    tick(1'b1, 32'h0020A423, 3'd0, 5'd5, 1'b0, 1'b0);
    tick(1'b0, 0, 0, 0, 1'b1, 1'b0);
    chk("fl_valid", ov32, 0);
    chk("fl_ready", ir64, 1);
    tick(1'b1, 32'h001000EF, 3'd3, 5'd6, 1'b0, 1'b0);
    tick(1'b1, 32'hFE000EE3, 3'd7, 5'd7, 1'b1, 1'b0);
    chk("fl_acc_valid", ov64, 0);
    chk("fl_acc_ready", ir32, 1);
    chk("fl_acc_err", err32, 2);
    for (int k = 0; k < 3; k++) tick(1'b0, 0, 0, 0, 1'b0, 1'b1);
    // illegal stream saturates the counter
    for (int k = 0; k < 300; k++) tick(1'b1, $urandom, 3'd7, 5'($urandom), 1'b0, 1'b1);
    chk("ill_imm", imm64, 0);
    chk("ill_flag", il32, 1);
    chk("err_sat", err32, 255);
    // random traffic
    for (int k = 0; k < 500; k++)
      tick($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), 5'($urandom),
           $urandom_range(0, 40) == 0, $urandom_range(0, 4) != 0);
    // asynchronous reset mid-stall
    tick(1'b1, 32'hFFF00093, 3'd0, 5'd9, 1'b0, 1'b0);
    tick(1'b1, 32'hFFF00093, 3'd0, 5'd10, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", ov32, 0);
    chk("arst_imm", imm64, 0);
    chk("arst_err", err32, 0);
    chk("arst_ready", ir64, 1);
    q.delete();
    err_m = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tick(1'b1, 32'h123452B7, 3'd4, 5'd11, 1'b0, 1'b1);
    chk("post_rst_imm", imm32, 32'h12345000);
    chk("post_rst_tag", tag32, 11);
    tick(1'b0, 0, 0, 0, 1'b0, 1'b1);
    check_outputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
